lnzd_sparse_scanner: RTL

- Sequential successor to the single-level LNZD merge cell: accepts one DATA_WIDTH-bit activation mask per transaction.
- Emits the positions of all set bits, lowest index first, one position per output handshake. Each transaction's output stream ends with a last flag.
- Sits between the activation buffer and the sparse hash/index datapath, so downstream logic only sees nonzero positions.
- Contains a parametrised LNZD tree (log2(DATA_WIDTH) levels of LSB-priority merge) plus a mask register, handshake control and an ordinal counter.

---
 rtl/lnzd_sparse_scanner.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lnzd_sparse_scanner.sv
// lnzd_sparse_scanner: accepts one activation mask per transaction and emits
// the positions of its set bits, lowest index first, one per output handshake.
// A parametrised LSB-priority LNZD tree locates the current lowest set bit of
// the held mask; each accepted beat clears that bit until the mask is spent.
module lnzd_sparse_scanner #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(DATA_WIDTH)-1:0] out_pos,
  output logic [$clog2(DATA_WIDTH):0]   out_idx,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          out_zero,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int POS_WIDTH = $clog2(DATA_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [POS_WIDTH:0]    idx_q;
  logic                  zero_q;

  // mask with its lowest set bit removed; also the single-bit test for last
  logic [DATA_WIDTH-1:0] mask_pop_d;
  logic                  scan_s;
  logic                  last_s;
  logic                  in_xfer_s;

  // tree nodes: level 0 are the mask bits, level POS_WIDTH is the root
  logic [POS_WIDTH-1:0]  node_pos_s [POS_WIDTH+1][DATA_WIDTH];
  logic                  node_vld_s [POS_WIDTH+1][DATA_WIDTH];
  logic [POS_WIDTH-1:0]  tree_pos_s;
  logic                  tree_vld_s;

  // LNZD tree: each merge prefers the LSB half, else prefixes a 1 onto the MSB half
  always_comb begin
    for (int l = 0; l <= POS_WIDTH; l++) begin
      for (int n = 0; n < DATA_WIDTH; n++) begin
        node_vld_s[l][n] = 1'b0;
        node_pos_s[l][n] = {POS_WIDTH{1'b0}};
      end
    end
    for (int n = 0; n < DATA_WIDTH; n++) begin
      node_vld_s[0][n] = mask_q[n];
    end
    for (int l = 1; l <= POS_WIDTH; l++) begin
      for (int n = 0; n < (DATA_WIDTH >> l); n++) begin
        node_vld_s[l][n] = node_vld_s[l-1][2*n] | node_vld_s[l-1][2*n+1];
        if (node_vld_s[l-1][2*n]) begin
          node_pos_s[l][n] = node_pos_s[l-1][2*n];
        end else begin
          node_pos_s[l][n] = node_pos_s[l-1][2*n+1] | (POS_WIDTH'(1) << (l-1));
        end
      end
    end
  end

  assign tree_pos_s = node_pos_s[POS_WIDTH][0];
  assign tree_vld_s = node_vld_s[POS_WIDTH][0];

  assign mask_pop_d = mask_q & (mask_q - {{(DATA_WIDTH-1){1'b0}}, 1'b1});
  assign scan_s     = (state_q == ST_SCAN);
  assign last_s     = (mask_pop_d == {DATA_WIDTH{1'b0}}) | zero_q;

  // Outputs are pure functions of the held state; an empty mask reports position 0
  assign out_valid = scan_s;
  assign out_last  = scan_s & last_s;
  assign out_zero  = scan_s & zero_q;
  assign out_pos   = tree_vld_s ? tree_pos_s : {POS_WIDTH{1'b0}};
  assign out_idx   = idx_q;
  assign out_tag   = tag_q;

  // A new mask is taken when idle, or on the final accepted beat (zero-bubble)
  assign in_ready  = ~scan_s | (out_valid & out_last & out_ready);
  assign in_xfer_s = in_valid & in_ready;

  // Scanner FSM: load mask, pop one set bit per accepted beat, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= {DATA_WIDTH{1'b0}};
      tag_q   <= {TAG_WIDTH{1'b0}};
      idx_q   <= {(POS_WIDTH+1){1'b0}};
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_xfer_s) begin
            state_q <= ST_SCAN;
            mask_q  <= in_data;
            tag_q   <= in_tag;
            idx_q   <= {(POS_WIDTH+1){1'b0}};
            zero_q  <= (in_data == {DATA_WIDTH{1'b0}});
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (in_xfer_s) begin
            state_q <= ST_SCAN;
            mask_q  <= in_data;
            tag_q   <= in_tag;
            idx_q   <= {(POS_WIDTH+1){1'b0}};
            zero_q  <= (in_data == {DATA_WIDTH{1'b0}});
          end else if (out_ready && last_s) begin
            state_q <= ST_IDLE;
            mask_q  <= {DATA_WIDTH{1'b0}};
            idx_q   <= {(POS_WIDTH+1){1'b0}};
            zero_q  <= 1'b0;
          end else if (out_ready) begin
            mask_q  <= mask_pop_d;
            idx_q   <= idx_q + {{POS_WIDTH{1'b0}}, 1'b1};
          end else begin
            state_q <= ST_SCAN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mask_q  <= {DATA_WIDTH{1'b0}};
          idx_q   <= {(POS_WIDTH+1){1'b0}};
          zero_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
